// File: rtl/jsop_pkg.sv
// Shared constants and types for the JS-opcode instruction path.
// Beat ordering: halfword 0 is the most significant slice.
package jsop_pkg;

    localparam int INSTR_W     = 48;
    localparam int INSTR_BYTES = 6;
    localparam int BEATS       = 3;
    localparam int HW_W        = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_e;

    function automatic logic [INSTR_W-1:0] place_beat(
        input logic [INSTR_W-1:0] w,
        input logic [1:0]         b,
        input logic [HW_W-1:0]    d
    );
        logic [INSTR_W-1:0] r;
        r = w;
        unique case (b)
            2'd0:    r[47:32] = d;
            2'd1:    r[31:16] = d;
            default: r[15:0]  = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hatch_ibuf.sv
// Two-entry valid/ready FIFO with synchronous flush.
// Flush has priority over both push and pop.
module hatch_ibuf #(
    parameter int DW = 80
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_q;
    logic          rd_q;
    logic [1:0]    cnt_q;
    logic          pop_ok;

    assign pop_ok  = pop_i && (cnt_q != 2'd0);
    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush_i) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= ~wr_q;
            end
            if (pop_ok) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/hatch_prefetch.sv
// Instruction prefetch: three halfword reads per 48-bit instruction,
// streamed sequentially into a two-entry output buffer.
module hatch_prefetch
    import jsop_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 16,
    parameter int DEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               redir_valid,
    input  logic [ADDR_W-1:0]  redir_addr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_addr,
    output logic               align_err,
    output logic               mem_rd,
    output logic [MEM_AW-1:0]  mem_addr,
    input  logic [HW_W-1:0]    mem_rdata
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [1:0]          beat_q, beat_d;
    logic                pend_q, pend_d;
    logic [1:0]          pbeat_q, pbeat_d;
    logic [INSTR_W-1:0]  asm_q, asm_d;
    logic                align_q, align_d;

    logic                issue;
    logic                rsp;
    logic                push;
    logic                start_ok;
    logic [1:0]          occ;
    logic [ADDR_W+INSTR_W-1:0] push_data;
    logic [ADDR_W+INSTR_W-1:0] head;

    // A new instruction reserves its buffer slot at beat 0; later
    // beats of that instruction are always allowed to proceed.
    assign start_ok = ({1'b0, occ} + {2'b0, pend_q}) < 3'(DEPTH);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        beat_d  = beat_q;
        pend_d  = 1'b0;
        pbeat_d = pbeat_q;
        asm_d   = asm_q;
        align_d = align_q;
        issue   = 1'b0;
        rsp     = pend_q && !redir_valid;
        push    = rsp && (pbeat_q == 2'd2);

        if (rsp) begin
            asm_d = place_beat(asm_q, pbeat_q, mem_rdata);
        end

        if (redir_valid) begin
            pc_d   = redir_addr;
            beat_d = 2'd0;
            if (redir_addr[0]) begin
                align_d = 1'b1;
                state_d = HALT;
            end else begin
                state_d = RUN;
            end
        end else if (state_q == RUN && (beat_q != 2'd0 || start_ok)) begin
            issue   = 1'b1;
            pend_d  = 1'b1;
            pbeat_d = beat_q;
            if (beat_q == 2'(BEATS - 1)) begin
                beat_d = 2'd0;
                pc_d   = pc_q + ADDR_W'(INSTR_BYTES);
            end else begin
                beat_d = beat_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            pc_q    <= '0;
            beat_q  <= 2'd0;
            pend_q  <= 1'b0;
            pbeat_q <= 2'd0;
            asm_q   <= '0;
            align_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            beat_q  <= beat_d;
            pend_q  <= pend_d;
            pbeat_q <= pbeat_d;
            asm_q   <= asm_d;
            align_q <= align_d;
        end
    end

    // pc has already stepped past the instruction whose last beat lands now.
    assign push_data = {pc_q - ADDR_W'(INSTR_BYTES),
                        place_beat(asm_q, 2'd2, mem_rdata)};

    hatch_ibuf #(
        .DW(ADDR_W + INSTR_W)
    ) u_ibuf (
        .clk        (clk),
        .rst_b      (rst_b),
        .flush_i    (redir_valid),
        .push_i     (push),
        .push_data_i(push_data),
        .pop_i      (instr_ready),
        .valid_o    (instr_valid),
        .data_o     (head),
        .count_o    (occ)
    );

    assign instr_addr = head[ADDR_W+INSTR_W-1:INSTR_W];
    assign instr      = head[INSTR_W-1:0];
    assign align_err  = align_q;
    assign mem_rd     = issue;
    assign mem_addr   = pc_q[MEM_AW:1] + MEM_AW'(beat_q);

endmodule

// File: tb/tb_hatch_prefetch.sv
// Scoreboard bench for hatch_prefetch with a synchronous-read ROM model.
// Handshakes are checked by a monitor against an expected queue.
module tb_hatch_prefetch;

    logic        clk;
    logic        rst_b;
    logic        redir_valid;
    logic [31:0] redir_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [47:0] instr;
    logic [31:0] instr_addr;
    logic        align_err;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    logic [79:0] q[$];

    hatch_prefetch dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .redir_valid(redir_valid),
        .redir_addr (redir_addr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_addr (instr_addr),
        .align_err  (align_err),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [15:0] a);
        case (a)
            16'd0:   return 16'h1111;
            16'd1:   return 16'h2222;
            16'd2:   return 16'h3333;
            default: return 16'hA000 | a;
        endcase
    endfunction

    always @(posedge clk) begin
        mem_rdata <= mem_rd ? rom(mem_addr) : 16'hDEAD;
    end

    always @(negedge clk) begin
        if (rst_b && instr_valid && instr_ready && !redir_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_instr got addr=%h instr=%h want none",
                         instr_addr, instr);
            end else begin
                logic [79:0] e;
                e = q.pop_front();
                if ({instr_addr, instr} !== e) begin
                    errors++;
                    $display("FAIL instr got addr=%h instr=%h want addr=%h instr=%h",
                             instr_addr, instr, e[79:48], e[47:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [79:0] act,
                       input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic redirect(input logic [31:0] a, input logic rdy);
        step();
        redir_valid = 1'b1;
        redir_addr  = a;
        instr_ready = rdy;
        q.delete();
        samp();
        chk("mem_rd_in_redirect", 80'(mem_rd), 80'(0));
        step();
        redir_valid = 1'b0;
    endtask

    task automatic expect_instr(input logic [31:0] a, input logic [47:0] d);
        q.push_back({a, d});
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && q.size() != 0; i++) begin
            step();
            samp();
        end
        chk("drain_left", 80'(q.size()), 80'(0));
        step();
        instr_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_b       = 1'b0;
        redir_valid = 1'b0;
        redir_addr  = '0;
        instr_ready = 1'b0;

        samp();
        chk("rst_valid", 80'(instr_valid), 80'(0));
        chk("rst_instr", 80'(instr), 80'(0));
        chk("rst_iaddr", 80'(instr_addr), 80'(0));
        chk("rst_mem_rd", 80'(mem_rd), 80'(0));
        chk("rst_mem_addr", 80'(mem_addr), 80'(0));
        chk("rst_align", 80'(align_err), 80'(0));
        step();
        rst_b = 1'b1;
        step();
        samp();
        chk("idle_mem_rd", 80'(mem_rd), 80'(0));

        // cold start and streaming
        redirect(32'h0, 1'b1);
        expect_instr(32'h0, 48'h111122223333);
        expect_instr(32'h6, 48'hA003A004A005);
        expect_instr(32'hC, 48'hA006A007A008);
        samp();
        chk("cs_rd1", 80'({mem_rd, mem_addr}), 80'({1'b1, 16'd0}));
        step(); samp();
        chk("cs_rd2", 80'({mem_rd, mem_addr}), 80'({1'b1, 16'd1}));
        step(); samp();
        chk("cs_rd3", 80'({mem_rd, mem_addr}), 80'({1'b1, 16'd2}));
        step(); samp();
        chk("cs_n4_valid", 80'(instr_valid), 80'(0));
        chk("cs_rd4", 80'({mem_rd, mem_addr}), 80'({1'b1, 16'd3}));
        step(); samp();
        chk("cs_n5_valid", 80'(instr_valid), 80'(1));
        chk("cs_rd5", 80'(mem_addr), 80'(4));
        step(); samp();
        chk("cs_n6_valid", 80'(instr_valid), 80'(0));
        chk("cs_rd6", 80'(mem_addr), 80'(5));
        step(); samp();
        chk("cs_n7_valid", 80'(instr_valid), 80'(0));
        step(); samp();
        chk("cs_n8_valid", 80'(instr_valid), 80'(1));
        drain();

        // backpressure
        redirect(32'hC, 1'b0);
        expect_instr(32'hC, 48'hA006A007A008);
        expect_instr(32'h12, 48'hA009A00AA00B);
        expect_instr(32'h18, 48'hA00CA00DA00E);
        n = 0;
        for (int i = 0; i < 14; i++) begin
            samp();
            if (mem_rd) n++;
            step();
        end
        chk("bp_issues", 80'(n), 80'(6));
        samp();
        chk("bp_valid", 80'(instr_valid), 80'(1));
        chk("bp_head", 80'({instr_addr, instr}), {32'hC, 48'hA006A007A008});
        step();
        instr_ready = 1'b1;
        drain();

        // redirect one cycle after beat1 issues
        redirect(32'h0, 1'b1);
        samp();
        step(); samp();
        chk("mf_beat1", 80'({mem_rd, mem_addr}), 80'({1'b1, 16'd1}));
        redirect(32'h30, 1'b1);
        expect_instr(32'h30, 48'hA018A019A01A);
        samp();
        chk("mf_rd1", 80'({mem_rd, mem_addr}), 80'({1'b1, 16'h18}));
        chk("mf_v1", 80'(instr_valid), 80'(0));
        for (int i = 2; i <= 4; i++) begin
            step(); samp();
            chk("mf_v_low", 80'(instr_valid), 80'(0));
        end
        step(); samp();
        chk("mf_v5", 80'(instr_valid), 80'(1));
        drain();

        // odd redirect then recovery
        redirect(32'h7, 1'b0);
        samp();
        chk("odd_align", 80'(align_err), 80'(1));
        chk("odd_rd", 80'(mem_rd), 80'(0));
        step(); samp();
        chk("halt_rd", 80'(mem_rd), 80'(0));
        chk("halt_valid", 80'(instr_valid), 80'(0));
        redirect(32'h6, 1'b1);
        expect_instr(32'h6, 48'hA003A004A005);
        samp();
        chk("resume_rd", 80'({mem_rd, mem_addr}), 80'({1'b1, 16'd3}));
        chk("resume_align", 80'(align_err), 80'(1));
        drain();

        // reset with a full buffer
        redirect(32'h0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step();
        end
        samp();
        chk("full_valid", 80'(instr_valid), 80'(1));
        step();
        rst_b = 1'b0;
        #1;
        chk("ar_valid", 80'(instr_valid), 80'(0));
        chk("ar_instr", 80'(instr), 80'(0));
        chk("ar_iaddr", 80'(instr_addr), 80'(0));
        chk("ar_mem_rd", 80'(mem_rd), 80'(0));
        chk("ar_mem_addr", 80'(mem_addr), 80'(0));
        chk("ar_align", 80'(align_err), 80'(0));
        step();
        step();
        rst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            samp();
            chk("post_rst_rd", 80'(mem_rd), 80'(0));
            chk("post_rst_valid", 80'(instr_valid), 80'(0));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hatch_prefetch.md
Name: hatch_prefetch

Overview:
- Instruction prefetch/assembly stage directly upstream of the cpu hatch instruction input.
- Takes a byte-address redirect (branch/reset PC) from the cpu and reads the instruction store through a 16-bit synchronous-read port, three halfword beats per instruction.
- Assembles 48-bit JS-opcode instructions and streams them sequentially (PC += 6) into a 2-entry output buffer with a valid/ready handshake.
- Replaces the zero-latency combinational instruction lookup.

Parameters:
- ADDR_W, 32, byte-address width of the cpu side.
- MEM_AW, 16, halfword address width of the instruction store.
- DEPTH, 2, output buffer entries (fixed at 2; other values unsupported).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_b  in  1  asynchronous active-low reset.
- redir_valid  in  1  load new fetch PC.
- redir_addr  in  ADDR_W  byte address of the new instruction stream.
- instr_valid  out  1  head of buffer holds an instruction.
- instr_ready  in  1  cpu consumes head this cycle.
- instr  out  48  assembled instruction, first halfword in [47:32].
- instr_addr  out  ADDR_W  byte address of instr.
- align_err  out  1  sticky; set on redirect to an odd address.
- mem_rd  out  1  read strobe.
- mem_addr  out  MEM_AW  halfword address = byte_addr[MEM_AW:1].
- mem_rdata  in  16  read data, valid exactly one cycle after mem_rd.

Behaviour:
- Reset (async, rst_b low):
  - State IDLE; buffer empty; instr_valid=0, instr=0, instr_addr=0.
  - mem_rd=0, mem_addr=0, align_err=0, pc=0, beat=0, pending=0.
- States:
  - IDLE: no fetch PC yet; waits for redir_valid.
  - RUN: fetching sequentially.
  - HALT: after an alignment error; only a valid redirect leaves it.
- Redirect (redir_valid=1), accepted in any state:
  - Flush both buffer entries; instr_valid=0 in the next cycle.
  - Discard the partial assembly, beat=0.
  - Drop the response for any mem_rd issued in the same or previous cycle, tracked by a pending bit cleared on redirect.
  - pc <= redir_addr.
  - If redir_addr[0]=1: align_err <= 1, state HALT. Otherwise state RUN and align_err unchanged.
  - align_err clears only on reset.
- Issue rule in RUN:
  - mem_rd=1 with mem_addr=(pc>>1)+beat when (occupancy + assembling) < 2 and no redirect this cycle.
  - "assembling" = 1 while beat>0 or a beat is pending.
  - beat increments 0→1→2 per issue.
  - After beat 2 issues: pc <= pc+6, beat <= 0. PC wraps mod 2^ADDR_W.
  - mem_addr truncates to MEM_AW bits and wraps silently.
- Assembly:
  - Response of beat k lands in the shift register one cycle after its issue; beat0→[47:32], beat1→[31:16], beat2→[15:0].
  - The cycle after beat2's data is captured, the instruction and its address are written to the buffer tail.
- Latency:
  - Redirect at cycle N with an empty pipe → issues at N+1, N+2, N+3 → instr_valid=1 at N+5.
  - Steady state: one instruction per 3 cycles when the cpu is always ready.
- Buffer:
  - 2-entry FIFO; instr/instr_addr come from the head register, not combinational from mem_rdata.
  - Push and pop in the same cycle are legal at any occupancy, including full.
  - Never overflows, because issue is gated by reserved slots.
- Simultaneous events:
  - Redirect beats pop: the flush wins and the pop is ignored.
  - Redirect beats an arriving beat: the data is dropped.
- instr_ready while instr_valid=0 is ignored.

Decomposition:
- Shared package (jsop_pkg): INSTR_W=48, INSTR_BYTES=6, BEATS=3, beat→bit-slice mapping, and the state encoding enum {IDLE, RUN, HALT}.
- Natural sub-module: hatch_ibuf, the 2-entry valid/ready FIFO carrying {instr_addr, instr} with a synchronous flush.
- Top keeps the FSM, beat counter, pending/drop tracking and shift register.

Test Plan:
- Cold start: after reset, redirect to 0x0 at cycle N with ROM halfwords 0x1111,0x2222,0x3333 → mem_addr 0,1,2 at N+1..N+3; instr=0x111122223333, instr_addr=0 at N+5.
- Streaming with instr_ready=1: the next instruction has instr_addr=6 and mem_addr 3,4,5; instr_valid pulses every 3 cycles.
- Backpressure with instr_ready=0 from redirect to 0xC: exactly 2 instructions buffered (0xC, 0x12), mem_rd idle after 6 issues. Raise ready → 0xC, 0x12, 0x18 in order, nothing lost or duplicated.
- Redirect to 0x30 mid-fetch, one cycle after beat1 issues: old beat data dropped; instr_valid=0 until the instruction at 0x30 appears 5 cycles later; no stale address ever presented.
- Odd redirect to 0x7: align_err=1 next cycle, no mem_rd, HALT. A following redirect to 0x6 resumes fetching; align_err stays 1.
- Reset asserted mid-stream with a full buffer: all outputs are 0 asynchronously while rst_b=0; after release no mem_rd until a redirect.
